// File: rtl/pipelined_adder_pkg.sv
// -----------------------------------------------------------------------------
// pipelined_adder_pkg
// Shared definitions for the pipelined add/subtract unit.
//   - FLAG_* : bit positions of the C/V/Z/N flags in the status-register view
//   - flags_t: packed status flags, indexed by FLAG_*
//   - chunk_width(): bits handled by each pipeline stage
// No ports (package).
// -----------------------------------------------------------------------------
package pipelined_adder_pkg;

    localparam int FLAG_C    = 0;
    localparam int FLAG_V    = 1;
    localparam int FLAG_Z    = 2;
    localparam int FLAG_N    = 3;
    localparam int NUM_FLAGS = 4;

    typedef logic [NUM_FLAGS-1:0] flags_t;

    // Each stage adds one equal-width slice of the operands.
    function automatic int chunk_width(input int width, input int stages);
        return width / stages;
    endfunction

    // Assemble the status flags in status-register bit order.
    function automatic flags_t pack_flags(input logic c, input logic v,
                                          input logic z, input logic n);
        flags_t f;
        f         = '0;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        f[FLAG_Z] = z;
        f[FLAG_N] = n;
        return f;
    endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// -----------------------------------------------------------------------------
// pipelined_adder_if
// Valid/ready bus for the pipelined add/subtract unit.
//   Input side : in_valid, in_ready, a, b, sub
//   Output side: out_valid, out_ready, sum, c_flag, v_flag, z_flag, n_flag
// Modports:
//   master - the client that issues operands and consumes results
//   slave  - the adder itself
// -----------------------------------------------------------------------------
interface pipelined_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_flag;
    logic             v_flag;
    logic             z_flag;
    logic             n_flag;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, c_flag, v_flag, z_flag, n_flag
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, c_flag, v_flag, z_flag, n_flag
    );
endinterface

// File: rtl/pipelined_adder_slice.sv
// -----------------------------------------------------------------------------
// pipelined_adder_slice
// Combinational CHUNK-bit ripple of full-adder cells.
//   a, b  in  CHUNK  operand slices (b already inverted for subtraction)
//   cin   in  1      carry into bit 0
//   sum   out CHUNK  slice sum
//   cout  out 1      carry out of the slice MSB
//   cmsb  out 1      carry into the slice MSB (used for signed overflow)
// -----------------------------------------------------------------------------
module pipelined_adder_slice #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             cmsb
);
    logic [CHUNK:0] carry;

    // Classic ripple: each cell produces its sum bit and the carry for the
    // next cell up. Kept in one block so the chain is a single combinational
    // cone rather than a net loop of per-bit assigns.
    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = carry[CHUNK];
    assign cmsb = carry[CHUNK-1];
endmodule

// File: rtl/pipelined_adder.sv
// -----------------------------------------------------------------------------
// pipelined_adder
// Pipelined add/subtract unit: WIDTH-bit operands are split into STAGES equal
// chunks and one chunk is added per clock, with the carry registered between
// chunks. Produces sum plus C/V/Z/N flags. WIDTH must be divisible by STAGES.
//   clk  in  1   rising-edge clock
//   rst  in  1   asynchronous active-high reset; flushes in-flight work
//   bus  slave modport of pipelined_adder_if (valid/ready on both sides)
// -----------------------------------------------------------------------------
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    pipelined_adder_if.slave bus
);
    localparam int CHUNK = chunk_width(WIDTH, STAGES);
    localparam int LAST  = STAGES - 1;

    // Per-stage registers. a_q/b_q carry the operand chunks not yet consumed
    // (skew), sum_q accumulates finished chunks on their way to the output
    // (de-skew), cry_q is the carry handed to the next stage.
    logic             vld_q [STAGES];
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] sum_q [STAGES];
    logic             cry_q [STAGES];
    flags_t           flags_q;

    // Per-stage inputs and combinational results.
    logic             st_vld  [STAGES];
    logic [WIDTH-1:0] st_a    [STAGES];
    logic [WIDTH-1:0] st_b    [STAGES];
    logic [WIDTH-1:0] st_sum  [STAGES];
    logic [WIDTH-1:0] st_next [STAGES];
    logic             st_cin  [STAGES];
    logic             st_cout [STAGES];
    logic             st_cmsb [STAGES];

    logic advance;

    // One global stall: the whole pipe moves only when the output slot is
    // empty or being taken this cycle.
    assign advance = ~vld_q[LAST] | bus.out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam logic [WIDTH-1:0] MASK = WIDTH'({CHUNK{1'b1}}) << (k * CHUNK);

        logic [CHUNK-1:0] chunk_sum;

        if (k == 0) begin : g_first
            // B is inverted on entry and sub becomes the initial carry, so a
            // subtraction needs no further bookkeeping down the pipe.
            assign st_vld[k] = bus.in_valid;
            assign st_a[k]   = bus.a;
            assign st_b[k]   = bus.b ^ {WIDTH{bus.sub}};
            assign st_cin[k] = bus.sub;
            assign st_sum[k] = '0;
        end else begin : g_next
            assign st_vld[k] = vld_q[k-1];
            assign st_a[k]   = a_q[k-1];
            assign st_b[k]   = b_q[k-1];
            assign st_cin[k] = cry_q[k-1];
            assign st_sum[k] = sum_q[k-1];
        end

        pipelined_adder_slice #(
            .CHUNK (CHUNK)
        ) u_slice (
            .a    (st_a[k][k*CHUNK +: CHUNK]),
            .b    (st_b[k][k*CHUNK +: CHUNK]),
            .cin  (st_cin[k]),
            .sum  (chunk_sum),
            .cout (st_cout[k]),
            .cmsb (st_cmsb[k])
        );

        assign st_next[k] = (st_sum[k] & ~MASK) | (WIDTH'(chunk_sum) << (k * CHUNK));
    end

    // Pipeline registers. Valid bits follow every advance so bubbles flow
    // through; data only loads for a valid slot, which keeps the output sum
    // and flags frozen until a real result arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= 1'b0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                sum_q[k] <= '0;
                cry_q[k] <= 1'b0;
            end
            flags_q <= '0;
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= st_vld[k];
                if (st_vld[k]) begin
                    a_q[k]   <= st_a[k];
                    b_q[k]   <= st_b[k];
                    sum_q[k] <= st_next[k];
                    cry_q[k] <= st_cout[k];
                end
            end
            if (st_vld[LAST]) begin
                flags_q <= pack_flags(st_cout[LAST],
                                      st_cout[LAST] ^ st_cmsb[LAST],
                                      ~|st_next[LAST],
                                      st_next[LAST][WIDTH-1]);
            end
        end
    end

    assign bus.in_ready  = advance;
    assign bus.out_valid = vld_q[LAST];
    assign bus.sum       = sum_q[LAST];
    assign bus.c_flag    = flags_q[FLAG_C];
    assign bus.v_flag    = flags_q[FLAG_V];
    assign bus.z_flag    = flags_q[FLAG_Z];
    assign bus.n_flag    = flags_q[FLAG_N];
endmodule

// File: tb/tb_pipelined_adder.sv
// -----------------------------------------------------------------------------
// tb_pipelined_adder
// Self-checking bench for pipelined_adder at WIDTH=8, STAGES=2: fixed vectors,
// back-to-back issue, output stall, mid-flight reset and a long random stream
// scored against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_pipelined_adder;
    localparam int WIDTH  = 8;
    localparam int STAGES = 2;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic [7:0] sum;
        logic       c;
        logic       v;
        logic       z;
        logic       n;
    } vec_t;

    typedef struct {
        logic [7:0] sum;
        logic       c;
        logic       v;
        logic       z;
        logic       n;
        int         acc_cyc;
    } exp_t;

    logic clk;
    logic rst;

    pipelined_adder_if #(.WIDTH(WIDTH)) bus();

    pipelined_adder #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    vec_t vecs[7];
    exp_t exp_q[$];
    int   num_vectors     = 0;
    int   num_miscompares = 0;

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference behaviour from plain integer arithmetic: unsigned range gives
    // the carry/no-borrow, signed range gives the overflow.
    function automatic exp_t refModel(input logic [7:0] a, input logic [7:0] b, input logic sub);
        exp_t e;
        int   ua;
        int   ub;
        int   sa;
        int   sb;
        int   res;
        int   sres;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sub) begin
            res  = ua - ub;
            sres = sa - sb;
            e.c  = (ua >= ub);
        end else begin
            res  = ua + ub;
            sres = sa + sb;
            e.c  = (res > 255);
        end
        e.sum     = res[7:0];
        e.v       = (sres > 127) || (sres < -128);
        e.z       = (e.sum == 8'h00);
        e.n       = e.sum[7];
        e.acc_cyc = 0;
        return e;
    endfunction

    function automatic logic [31:0] packResult(input logic [7:0] s, input logic c, input logic v,
                                               input logic z, input logic n);
        return {20'd0, s, c, v, z, n};
    endfunction

    function automatic logic [31:0] dutResult();
        return packResult(bus.sum, bus.c_flag, bus.v_flag, bus.z_flag, bus.n_flag);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        num_vectors++;
        if (actual !== expected) begin
            num_miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one operation for a single cycle; the unit is idle so it must be
    // accepted immediately.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic sub);
        bus.a         = a;
        bus.b         = b;
        bus.sub       = sub;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        checkOutput("in_ready_idle", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
    endtask

    // Single operation through an empty pipe: nothing after one cycle, the
    // result after two, then the slot drains.
    task automatic runVector(input vec_t v, input string tag);
        applyStimulus(v.a, v.b, v.sub);
        checkOutput({tag, "_early"}, 32'(bus.out_valid), 32'd0);
        step();
        checkOutput({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        checkOutput({tag, "_result"}, dutResult(), packResult(v.sum, v.c, v.v, v.z, v.n));
        step();
        checkOutput({tag, "_drain"}, 32'(bus.out_valid), 32'd0);
    endtask

    // Streaming scoreboard: random operands, optional random valid/ready
    // gaps and a forced stall window; every output is compared to the head
    // of the expected queue.
    task automatic runStream(input string tag, input int n_ops, input int stall_at, input int stall_len,
                             input bit rand_ready, input bit rand_valid, input bit check_lat);
        int   sent;
        int   got;
        int   cyc;
        int   budget;
        exp_t e;
        sent   = 0;
        got    = 0;
        cyc    = 0;
        budget = n_ops * 20 + 50;
        exp_q.delete();
        while (got < n_ops && cyc < budget) begin
            if (sent < n_ops && (!rand_valid || $urandom_range(0, 3) != 0)) begin
                bus.in_valid = 1'b1;
                bus.a        = 8'($urandom);
                bus.b        = 8'($urandom);
                bus.sub      = 1'($urandom_range(0, 1));
            end else begin
                bus.in_valid = 1'b0;
            end
            if (cyc >= stall_at && cyc < stall_at + stall_len)
                bus.out_ready = 1'b0;
            else if (rand_ready)
                bus.out_ready = ($urandom_range(0, 2) != 0);
            else
                bus.out_ready = 1'b1;
            #3;
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    checkOutput({tag, "_spurious"}, 32'(bus.out_valid), 32'd0);
                end else begin
                    checkOutput({tag, "_result"}, dutResult(),
                                packResult(exp_q[0].sum, exp_q[0].c, exp_q[0].v, exp_q[0].z, exp_q[0].n));
                    if (check_lat)
                        checkOutput({tag, "_latency"}, 32'(cyc - exp_q[0].acc_cyc), 32'(STAGES));
                    if (bus.out_ready) begin
                        void'(exp_q.pop_front());
                        got++;
                    end
                end
                if (!bus.out_ready)
                    checkOutput({tag, "_stall_in_ready"}, 32'(bus.in_ready), 32'd0);
            end
            if (bus.in_valid && bus.in_ready) begin
                e         = refModel(bus.a, bus.b, bus.sub);
                e.acc_cyc = cyc;
                exp_q.push_back(e);
                sent++;
            end
            step();
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        checkOutput({tag, "_completed"}, 32'(got), 32'(n_ops));
    endtask

    // Main sequence.
    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;

        vecs[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0, 1'b0, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset_result", dutResult(), 32'd0);
        checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd1);
        rst = 1'b0;
        step();

        for (int i = 0; i < 7; i++)
            runVector(vecs[i], $sformatf("vec%0d", i));

        // Three operations on consecutive cycles come back on consecutive
        // cycles, in order.
        for (int c = 0; c < 6; c++) begin
            if (c < 3) begin
                bus.in_valid = 1'b1;
                bus.a        = vecs[1 + c].a;
                bus.b        = vecs[1 + c].b;
                bus.sub      = vecs[1 + c].sub;
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (c >= 2 && c < 5) begin
                checkOutput($sformatf("b2b%0d_valid", c), 32'(bus.out_valid), 32'd1);
                checkOutput($sformatf("b2b%0d_result", c), dutResult(),
                            packResult(vecs[c - 1].sum, vecs[c - 1].c, vecs[c - 1].v,
                                       vecs[c - 1].z, vecs[c - 1].n));
            end else begin
                checkOutput($sformatf("b2b%0d_idle", c), 32'(bus.out_valid), 32'd0);
            end
            step();
        end

        // Six back-to-back ops with out_ready held low for three cycles.
        runStream("stall", 6, 3, 3, 1'b0, 1'b0, 1'b0);
        step();

        // Reset with two operations in flight.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.a         = 8'h12;
        bus.b         = 8'h34;
        bus.sub       = 1'b0;
        step();
        bus.a   = 8'h56;
        bus.b   = 8'h11;
        bus.sub = 1'b1;
        step();
        bus.in_valid = 1'b0;
        checkOutput("pre_reset_valid", 32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("mid_reset_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("mid_reset_result", dutResult(), 32'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("post_reset_idle", 32'(bus.out_valid), 32'd0);
            step();
        end
        runVector('{8'h21, 8'h43, 1'b0, 8'h64, 1'b0, 1'b0, 1'b0, 1'b0}, "after_reset");

        // Latency check with input gaps and no backpressure.
        runStream("latency", 40, 0, 0, 1'b0, 1'b1, 1'b1);
        step();

        // Long random run with random valid and ready gaps.
        runStream("random", 1000, 0, 0, 1'b1, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", num_vectors, num_miscompares);
        $finish;
    end
endmodule
